// File: rtl/lab3_mem_line_word_adapter.sv
// lab3_mem_line_word_adapter: splits 16B cache-line requests into four 4B word requests and gathers the replies
package lab3_mem_msgs_pkg;
  localparam logic [2:0] MEM_READ = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;
  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module lab3_mem_line_word_adapter
  import lab3_mem_msgs_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          linereq_val,
  output logic          linereq_rdy,
  input  mem_req_16B_t  linereq_msg,
  output logic          lineresp_val,
  input  logic          lineresp_rdy,
  output mem_resp_16B_t lineresp_msg,
  output logic          wordreq_val,
  input  logic          wordreq_rdy,
  output mem_req_4B_t   wordreq_msg,
  input  logic          wordresp_val,
  output logic          wordresp_rdy,
  input  mem_resp_4B_t  wordresp_msg
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t       state, state_nxt;
  logic [2:0]   type_q;
  logic [7:0]   opaque_q;
  logic [27:0]  addr_q;
  logic [127:0] line_data, data_acc;
  logic [2:0]   req_cnt, resp_cnt;
  logic         linereq_go, lineresp_go, wordreq_go, wordresp_go;
  logic         unused;
  assign linereq_go = linereq_val && linereq_rdy;
  assign lineresp_go = lineresp_val && lineresp_rdy;
  assign wordreq_go = wordreq_val && wordreq_rdy;
  assign wordresp_go = wordresp_val && wordresp_rdy;
  assign unused = ^{linereq_msg.addr[3:0], linereq_msg.len, wordresp_msg.type_,
                    wordresp_msg.opaque[7:2], wordresp_msg.test, wordresp_msg.len};
  // state, latched line request, counters and response accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      type_q <= '0;
      opaque_q <= '0;
      addr_q <= '0;
      line_data <= '0;
      data_acc <= '0;
      req_cnt <= '0;
      resp_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (linereq_go) begin
        type_q <= linereq_msg.type_;
        opaque_q <= linereq_msg.opaque;
        addr_q <= linereq_msg.addr[31:4];
        line_data <= linereq_msg.data;
        data_acc <= '0;
        req_cnt <= '0;
        resp_cnt <= '0;
      end
      if (wordreq_go) req_cnt <= req_cnt + 3'd1;
      if (wordresp_go) begin
        resp_cnt <= resp_cnt + 3'd1;
        if (type_q == MEM_READ) data_acc[{resp_cnt[1:0], 5'b0} +: 32] <= wordresp_msg.data;
      end
    end
  end
  // next state: leave XFER on the cycle the fourth word response is taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = linereq_go ? XFER : IDLE;
      XFER: state_nxt = (wordresp_go && resp_cnt == 3'd3) ? RESP : XFER;
      RESP: state_nxt = lineresp_go ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // outputs; everything is held at zero while reset is asserted
  always_comb begin
    linereq_rdy = 1'b0;
    lineresp_val = 1'b0;
    wordreq_val = 1'b0;
    wordresp_rdy = 1'b0;
    wordreq_msg = '0;
    lineresp_msg = '0;
    if (reset) begin
      linereq_rdy = state == IDLE;
      lineresp_val = state == RESP;
      wordreq_val = state == XFER && req_cnt < 3'd4;
      wordresp_rdy = state == XFER && resp_cnt < 3'd4;
      wordreq_msg.type_ = type_q;
      wordreq_msg.opaque = {6'b0, req_cnt[1:0]};
      wordreq_msg.addr = {addr_q, req_cnt[1:0], 2'b00};
      wordreq_msg.data = (type_q == MEM_READ) ? 32'h0 : line_data[{req_cnt[1:0], 5'b0} +: 32];
      lineresp_msg.type_ = type_q;
      lineresp_msg.opaque = opaque_q;
      lineresp_msg.data = (type_q == MEM_READ) ? data_acc : 128'h0;
    end
  end
  // word responses must come back in issue order
  a_resp_order: assert property (@(posedge clk) disable iff (!reset)
    wordresp_go |-> wordresp_msg.opaque[1:0] == resp_cnt[1:0]);
endmodule

// File: tb/tb_lab3_mem_line_word_adapter.sv
// tb_lab3_mem_line_word_adapter: directed scoreboard bench with a one-cycle-latency word memory model
module tb_lab3_mem_line_word_adapter;
  import lab3_mem_msgs_pkg::*;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          linereq_val = 1'b0;
  logic          linereq_rdy;
  mem_req_16B_t  linereq_msg = '0;
  logic          lineresp_val;
  logic          lineresp_rdy = 1'b1;
  mem_resp_16B_t lineresp_msg;
  logic          wordreq_val;
  logic          wordreq_rdy = 1'b1;
  mem_req_4B_t   wordreq_msg;
  logic          wordresp_val = 1'b0;
  logic          wordresp_rdy;
  mem_resp_4B_t  wordresp_msg = '0;

  lab3_mem_line_word_adapter dut (
    .clk(clk), .reset(reset),
    .linereq_val(linereq_val), .linereq_rdy(linereq_rdy), .linereq_msg(linereq_msg),
    .lineresp_val(lineresp_val), .lineresp_rdy(lineresp_rdy), .lineresp_msg(lineresp_msg),
    .wordreq_val(wordreq_val), .wordreq_rdy(wordreq_rdy), .wordreq_msg(wordreq_msg),
    .wordresp_val(wordresp_val), .wordresp_rdy(wordresp_rdy), .wordresp_msg(wordresp_msg)
  );

  always #5 clk = ~clk;

  mem_req_4B_t   wq[$];
  mem_resp_16B_t lq[$];
  mem_resp_4B_t  pend[$];
  int            nvec = 0, nerr = 0, cyc = 0, acc_cyc = 0, resp_seen = 0;
  logic          accepted = 1'b0, lat_armed = 1'b0, rdy_toggle = 1'b0;
  logic          prev_wstall = 1'b0, prev_lstall = 1'b0;
  mem_req_4B_t   prev_wmsg = '0;
  mem_resp_16B_t prev_lmsg = '0;
  logic [3:0]    pat = 4'b1001;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a[31:4] == 28'h123) ? 32'hA0 + 32'(a[3:2]) : {a[27:0], 4'h5};
  endfunction

  task automatic step();
    mem_resp_4B_t r;
    @(negedge clk);
    cyc++;
    if (prev_wstall) chk("wordreq_hold", 256'({wordreq_val, wordreq_msg}), 256'({1'b1, prev_wmsg}));
    if (prev_lstall) chk("lineresp_hold", 256'({lineresp_val, lineresp_msg}), 256'({1'b1, prev_lmsg}));
    if (lineresp_val) chk("linereq_rdy_in_resp", 256'(linereq_rdy), 256'(0));
    if (wordreq_val && wordreq_rdy) begin
      chk("wordreq_expected", 256'(wq.size() != 0), 256'(1));
      if (wq.size() != 0) chk("wordreq_msg", 256'(wordreq_msg), 256'(wq.pop_front()));
      r = '0;
      r.type_ = wordreq_msg.type_;
      r.opaque = wordreq_msg.opaque;
      r.data = (wordreq_msg.type_ == MEM_READ) ? rd_word(wordreq_msg.addr) : 32'hFFFF_FFFF;
      pend.push_back(r);
    end
    if (wordresp_val && wordresp_rdy) begin
      void'(pend.pop_front());
      resp_seen++;
    end
    if (lineresp_val && lat_armed) begin
      chk("latency", 256'(cyc - acc_cyc), 256'(6));
      lat_armed = 1'b0;
    end
    if (lineresp_val && lineresp_rdy) begin
      chk("lineresp_expected", 256'(lq.size() != 0), 256'(1));
      if (lq.size() != 0) chk("lineresp_msg", 256'(lineresp_msg), 256'(lq.pop_front()));
    end
    if (linereq_val && linereq_rdy) begin
      accepted = 1'b1;
      acc_cyc = cyc;
    end
    prev_wstall = wordreq_val && !wordreq_rdy;
    prev_wmsg = wordreq_msg;
    prev_lstall = lineresp_val && !lineresp_rdy;
    prev_lmsg = lineresp_msg;
    @(posedge clk);
    #1;
    wordreq_rdy = rdy_toggle ? pat[cyc % 4] : 1'b1;
    wordresp_val = pend.size() != 0;
    wordresp_msg = (pend.size() != 0) ? pend[0] : '0;
  endtask

  task automatic send_line(input logic [2:0] t, input logic [31:0] a, input logic [7:0] op,
                           input logic [127:0] d);
    mem_req_4B_t   w;
    mem_resp_16B_t r;
    int            n;
    r = '0;
    r.type_ = t;
    r.opaque = op;
    for (int i = 0; i < 4; i++) begin
      w = '0;
      w.type_ = t;
      w.opaque = 8'(i);
      w.addr = {a[31:4], 2'(i), 2'b00};
      w.data = (t == MEM_READ) ? 32'h0 : d[32*i +: 32];
      wq.push_back(w);
      if (t == MEM_READ) r.data[32*i +: 32] = rd_word(w.addr);
    end
    lq.push_back(r);
    linereq_msg = '0;
    linereq_msg.type_ = t;
    linereq_msg.opaque = op;
    linereq_msg.addr = a;
    linereq_msg.data = d;
    linereq_val = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 50) begin
      step();
      n++;
    end
    linereq_val = 1'b0;
    if (!accepted) chk("linereq_accept", 256'(0), 256'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((lq.size() != 0 || pend.size() != 0) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("drain_timeout", 256'(lq.size()), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step();
    chk("reset_outputs", 256'({linereq_rdy, lineresp_val, wordreq_val, wordresp_rdy, lineresp_msg, wordreq_msg}), 256'(0));
    reset = 1'b1;
    step();
    chk("idle_linereq_rdy", 256'({linereq_rdy, lineresp_val, wordreq_val, wordresp_rdy}), 256'(4'b1000));
    // refill read with latency check
    lat_armed = 1'b1;
    send_line(MEM_READ, 32'h0000_1234, 8'h5A, 128'h0);
    drain();
    chk("lat_checked", 256'(lat_armed), 256'(0));
    // evict write
    send_line(MEM_WRITE, 32'h0000_0F70, 8'h33, 128'h44444444_33333333_22222222_11111111);
    drain();
    // stalling word memory
    rdy_toggle = 1'b1;
    send_line(MEM_READ, 32'h0000_3000, 8'h11, 128'h0);
    drain();
    send_line(MEM_WRITE, 32'h0000_3100, 8'h12, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    drain();
    rdy_toggle = 1'b0;
    // cache stalls the line response
    lineresp_rdy = 1'b0;
    send_line(MEM_READ, 32'h0000_4440, 8'h77, 128'h0);
    n = 0;
    while (!lineresp_val && n < 20) begin
      step();
      n++;
    end
    chk("lineresp_seen", 256'(lineresp_val), 256'(1));
    for (int i = 0; i < 5; i++) step();
    lineresp_rdy = 1'b1;
    drain();
    // back-to-back lines
    send_line(MEM_READ, 32'h0000_0100, 8'h01, 128'h0);
    send_line(MEM_WRITE, 32'h0000_0200, 8'h02, 128'h0F0F0F0F_F0F0F0F0_55AA55AA_AA55AA55);
    drain();
    chk("all_words_seen", 256'(wq.size()), 256'(0));
    // reset mid-transaction
    resp_seen = 0;
    send_line(MEM_READ, 32'h0000_5550, 8'h99, 128'h0);
    n = 0;
    while (resp_seen < 2 && n < 20) begin
      step();
      n++;
    end
    chk("two_resps", 256'(resp_seen), 256'(2));
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 256'({linereq_rdy, lineresp_val, wordreq_val, wordresp_rdy, lineresp_msg, wordreq_msg}), 256'(0));
    wq.delete();
    lq.delete();
    pend.delete();
    wordresp_val = 1'b0;
    wordresp_msg = '0;
    prev_wstall = 1'b0;
    prev_lstall = 1'b0;
    step();
    chk("held_reset_outputs", 256'({linereq_rdy, lineresp_val, wordreq_val, wordresp_rdy}), 256'(0));
    reset = 1'b1;
    step();
    chk("post_reset_idle", 256'({linereq_rdy, lineresp_val, wordreq_val, wordresp_rdy}), 256'(4'b1000));
    for (int i = 0; i < 10; i++) step();
    chk("no_stale_lineresp", 256'(lineresp_val), 256'(0));
    send_line(MEM_READ, 32'h0000_1230, 8'h3C, 128'h0);
    drain();
    chk("final_wq", 256'(wq.size()), 256'(0));
    chk("final_lq", 256'(lq.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
